// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops with masked toggle/set/clear/invert, parallel load,
// registered per-bit change flags and a saturating change counter with sticky flag.
module tff_bank #(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam int NW = $clog2(WIDTH + 1);
    localparam int SW = ((CNT_W > NW) ? CNT_W : NW) + 1;
    localparam logic [SW-1:0] CNT_MAX = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] diff;
    logic [NW-1:0]    n;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_nx;

    always_comb begin
        q_nx = q;
        if (load) begin
            q_nx = d;
        end else if (en) begin
            unique case (op)
                2'b00:   q_nx = q ^ t;
                2'b01:   q_nx = q | t;
                2'b10:   q_nx = q & ~t;
                default: q_nx = ~q;
            endcase
        end
    end

    assign diff = q ^ q_nx;

    always_comb begin
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + NW'(diff[i]);
        end
    end

    // Sum is one bit wider than either operand so the overflow is visible before clamping.
    assign sum    = {{(SW - CNT_W){1'b0}}, cnt} + {{(SW - NW){1'b0}}, n};
    assign cnt_nx = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= INIT;
            chg <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            q   <= q_nx;
            chg <= diff;
            if (clr_cnt) begin
                cnt <= '0;
                sat <= 1'b0;
            end else begin
                cnt <= cnt_nx;
                if (cnt_nx == {CNT_W{1'b1}}) begin
                    sat <= 1'b1;
                end
            end
        end
    end

    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        load |=> q == $past(d));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !load && !en |=> q == $past(q));
    a_toggle: assert property (@(posedge clk) disable iff (!rst_n)
        !load && en && op == 2'b00 |=> q == $past(q ^ t));
    a_invert: assert property (@(posedge clk) disable iff (!rst_n)
        !load && en && op == 2'b11 |=> q == ~$past(q));
    a_chg: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> chg == (q ^ $past(q)));
    a_sat: assert property (@(posedge clk) disable iff (!rst_n)
        sat |-> cnt == {CNT_W{1'b1}});

endmodule

// File: tb/tb_tff_bank.sv
// Directed and randomized check of tff_bank against a behavioural model of the bank.
module tb_tff_bank;

    localparam int               WIDTH = 8;
    localparam int               CNT_W = 4;
    localparam logic [WIDTH-1:0] INIT  = '0;
    localparam int               MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] t = '0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             clr_cnt = 1'b0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] chg;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    int vectors = 0;
    int errors  = 0;

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_chg;
    int               m_cnt;
    logic             m_sat;

    tff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .t(t), .load(load), .d(d),
        .clr_cnt(clr_cnt), .q(q), .chg(chg), .cnt(cnt), .sat(sat)
    );

    always #5 clk = ~clk;

    // Reference model: next value from the operation table, counter clamped arithmetically.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= INIT;
            m_chg <= '0;
            m_cnt <= 0;
            m_sat <= 1'b0;
        end else begin
            automatic logic [WIDTH-1:0] nq = m_q;
            automatic int               nc;
            if (load)            nq = d;
            else if (en) begin
                if (op == 2'd0)      nq = m_q ^ t;
                else if (op == 2'd1) nq = m_q | t;
                else if (op == 2'd2) nq = m_q & ~t;
                else                 nq = ~m_q;
            end
            nc = m_cnt + $countones(m_q ^ nq);
            if (nc > MAXC) nc = MAXC;
            m_chg <= m_q ^ nq;
            m_q   <= nq;
            if (clr_cnt) begin
                m_cnt <= 0;
                m_sat <= 1'b0;
            end else begin
                m_cnt <= nc;
                m_sat <= m_sat | (nc == MAXC);
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (q !== m_q) begin
            errors++;
            $display("FAIL cyc_q: dut=%h model=%h at %0t", q, m_q, $time);
        end
        if (chg !== m_chg) begin
            errors++;
            $display("FAIL cyc_chg: dut=%h model=%h at %0t", chg, m_chg, $time);
        end
        if (cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL cyc_cnt: dut=%0d model=%0d at %0t", cnt, m_cnt, $time);
        end
        if (sat !== m_sat) begin
            errors++;
            $display("FAIL cyc_sat: dut=%b model=%b at %0t", sat, m_sat, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] ec,
                           input int en_cnt, input logic es);
        chk({name, ".q"},   32'(q),   32'(eq));
        chk({name, ".chg"}, 32'(chg), 32'(ec));
        chk({name, ".cnt"}, 32'(cnt), 32'(en_cnt));
        chk({name, ".sat"}, 32'(sat), 32'(es));
    endtask

    task automatic step(input logic l, input logic [WIDTH-1:0] dv, input logic e, input logic [1:0] o,
                        input logic [WIDTH-1:0] tv, input logic c);
        @(negedge clk);
        load = l; d = dv; en = e; op = o; t = tv; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; en = 1'b0; clr_cnt = 1'b0; op = 2'b00; t = '0; d = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, limit %0d", 500000);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 8'h00, 8'h00, 0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        step(1, 8'hA5, 0, 2'b00, 8'h00, 0);
        chk_all("load_a5", 8'hA5, 8'hA5, 4, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 8'h00, 8'h00, 0, 1'b0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        step(0, 8'h00, 1, 2'b00, 8'h0F, 0);
        chk_all("tog1", 8'h0F, 8'h0F, 4, 1'b0);
        step(0, 8'h00, 1, 2'b00, 8'h0F, 0);
        chk_all("tog2", 8'h00, 8'h0F, 8, 1'b0);
        step(0, 8'h00, 1, 2'b00, 8'h0F, 1);
        chk_all("tog_clr", 8'h0F, 8'h0F, 0, 1'b0);
        step(0, 8'h00, 1, 2'b01, 8'hF0, 0);
        chk_all("set", 8'hFF, 8'hF0, 4, 1'b0);
        step(0, 8'h00, 1, 2'b10, 8'h3C, 0);
        chk_all("clear", 8'hC3, 8'h3C, 8, 1'b0);
        step(0, 8'h00, 1, 2'b11, 8'h00, 0);
        chk_all("invert_sat", 8'h3C, 8'hFF, 15, 1'b1);
        step(0, 8'h00, 1, 2'b11, 8'h5A, 0);
        chk_all("invert_hold_max", 8'hC3, 8'hFF, 15, 1'b1);
        step(0, 8'h00, 1, 2'b11, 8'h00, 1);
        chk_all("invert_clr", 8'h3C, 8'hFF, 0, 1'b0);
        step(1, 8'h00, 0, 2'b00, 8'h00, 0);
        chk_all("load_zero", 8'h00, 8'h3C, 4, 1'b0);
        step(1, 8'h55, 1, 2'b00, 8'hFF, 0);
        chk_all("load_prio", 8'h55, 8'h55, 8, 1'b0);
        step(0, 8'h00, 0, 2'b00, 8'hFF, 0);
        chk_all("hold", 8'h55, 8'h00, 8, 1'b0);
        step(0, 8'h00, 1, 2'b01, 8'h00, 0);
        chk_all("zero_mask", 8'h55, 8'h00, 8, 1'b0);
        step(1, 8'h55, 0, 2'b00, 8'h00, 0);
        chk_all("load_same", 8'h55, 8'h00, 8, 1'b0);
        step(1, 8'hAA, 1, 2'b11, 8'hFF, 1);
        chk_all("load_en_clr", 8'hAA, 8'hFF, 0, 1'b0);
        step(0, 8'h00, 1, 2'b11, 8'h00, 0);
        chk_all("sat_inv1", 8'h55, 8'hFF, 8, 1'b0);
        step(0, 8'h00, 1, 2'b11, 8'h00, 0);
        chk_all("sat_inv2", 8'hAA, 8'hFF, 15, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                idle_inputs();
                #($urandom_range(1, 4)) rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk) rst_n = 1'b1;
            end
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            op      = 2'($urandom_range(0, 3));
            t       = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            d       = WIDTH'($urandom);
            clr_cnt = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
